mw_stage_reg: RTL
=================

# mw_stage_reg

M/W pipeline boundary of the five-stage MIPS core. It captures the M-stage results at the end of each cycle: PC, instruction, ALU result, load data, multiply/divide result, write-back selector and the M-stage destination register `M_MUXM_RegDst_O`. It then produces the W-stage register-file write port (address, data, enable) and a retired-instruction counter. Its outputs drive the GRF write port and the W-stage forwarding path into D and E.

## Interface
Parameters:
- `WIDTH`, 32, datapath width of PC, instruction and data fields.
- `CNT_WIDTH`, 32, width of the retired-instruction counter.

Ports:
- `clk`  input  1  core clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `en`  input  1  capture enable; 0 = hold (W-stage stall).
- `clr`  input  1  synchronous bubble insert.
- `M_valid`  input  1  M-stage slot holds a real instruction.
- `M_PC`  input  WIDTH  PC of M-stage instruction.
- `M_Instr`  input  WIDTH  M-stage instruction word.
- `M_ALU_O`  input  WIDTH  ALU result.
- `M_DM_O`  input  WIDTH  load data, already extended.
- `M_MD_O`  input  WIDTH  HI/LO read result.
- `M_WDSel`  input  2  write-back source: 0 ALU, 1 DM, 2 PC+8, 3 MD.
- `M_MUXM_RegDst_O`  input  5  destination register; 0 = no write.
- `W_PC`  output  WIDTH  registered PC.
- `W_Instr`  output  WIDTH  registered instruction.
- `W_A3`  output  5  GRF write address.
- `W_WD`  output  WIDTH  GRF write data / W forwarding data.
- `W_RegWrite`  output  1  GRF write enable.
- `W_valid`  output  1  W slot holds a real instruction.
- `W_retired`  output  CNT_WIDTH  count of instructions that entered W.

## Operation
- Stored fields: `valid`, PC, Instr, ALU, DM, MD, WDSel, A3.
- Per-edge priority, highest first: `reset` > `clr` > `en` > hold.
- `reset`: every stored field = 0, `W_retired` = 0.
- `clr`: every stored field = 0, which inserts a bubble. `W_retired` is unchanged.
- `en`=1: every field loads its M-stage input. `valid` loads `M_valid`.
- `en`=0: every field holds its value.
- `W_retired` increments by 1 on an edge where `en`=1, `clr`=0, `reset`=0 and `M_valid`=1. It wraps modulo 2^CNT_WIDTH, so all-ones rolls over to 0.
- Write-back mux (combinational from stored fields):
  - WDSel 0 → ALU.
  - WDSel 1 → DM.
  - WDSel 2 → PC+8, computed modulo 2^WIDTH.
  - WDSel 3 → MD.
- `W_A3` = stored A3 when `valid`=1, else 0.
- `W_RegWrite` = `valid` AND (stored A3 ≠ 0).
- `W_WD` = mux result when `W_RegWrite`=1, else 0. A $0 target or an invalid slot therefore presents A3=0, WD=0, RegWrite=0 to the GRF and the forwarding logic.
- `W_valid` = stored `valid`.
- `W_PC` and `W_Instr` are driven from stored fields regardless of `valid`.

## Timing
- Latency is 1 cycle: M inputs sampled at edge N appear on W outputs after edge N, until the next capturing edge.
- Outputs after reset: `W_PC`=0, `W_Instr`=0, `W_A3`=0, `W_WD`=0, `W_RegWrite`=0, `W_valid`=0, `W_retired`=0.
- `W_WD`, `W_A3` and `W_RegWrite` are combinational from flops only. There is no combinational path from any M input.
- `clr` and `en`=0 asserted together: `clr` wins and a bubble is inserted.
- `reset` asserted mid-stream, with any `en`/`clr`: state is zeroed at that edge and the pending M instruction is not retired.
- `en`=0 with `M_valid`=1: no capture, counter unchanged. The instruction retires on the later edge where `en`=1.
- GRF write-then-read in the same cycle is handled by GRF internal bypass, not here.

## Test plan
- Reset: hold `reset`=1 two cycles with random M inputs → all outputs 0, `W_retired`=0.
- ALU write: `M_ALU_O`=0x1234_5678, WDSel=0, RegDst=5'd8, valid=1, en=1 → next cycle `W_A3`=8, `W_WD`=0x12345678, `W_RegWrite`=1, `W_retired`=1.
- Source select: `M_PC`=0x0000_3000 with WDSel=2, RegDst=31 → `W_WD`=0x0000_3008. WDSel=1 and WDSel=3 then give DM and MD values exactly. `M_PC`=0xFFFF_FFFC with WDSel=2 → `W_WD`=0x0000_0004.
- $0 target: RegDst=0, ALU=0xDEAD_BEEF, valid=1 → `W_RegWrite`=0, `W_WD`=0, `W_A3`=0. Counter still +1.
- Stall/flush: capture an instruction to $9, then `en`=0 for 3 cycles with new M inputs → W outputs held, counter unchanged. Then `clr`=1 with `en`=0 → bubble (all 0, `W_valid`=0), counter unchanged.
- Wrap: preload `W_retired` to all-ones via 2^CNT_WIDTH−1 retirements (run with CNT_WIDTH=4 for 15), then one more valid capture → `W_retired`=0.

Source files
------------

// File: rtl/mw_stage_reg.sv
// mw_stage_reg: M/W pipeline register producing the GRF write port and a retired-instruction counter.
module mw_stage_reg #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 M_valid,
    input  logic [WIDTH-1:0]     M_PC,
    input  logic [WIDTH-1:0]     M_Instr,
    input  logic [WIDTH-1:0]     M_ALU_O,
    input  logic [WIDTH-1:0]     M_DM_O,
    input  logic [WIDTH-1:0]     M_MD_O,
    input  logic [1:0]           M_WDSel,
    input  logic [4:0]           M_MUXM_RegDst_O,
    output logic [WIDTH-1:0]     W_PC,
    output logic [WIDTH-1:0]     W_Instr,
    output logic [4:0]           W_A3,
    output logic [WIDTH-1:0]     W_WD,
    output logic                 W_RegWrite,
    output logic                 W_valid,
    output logic [CNT_WIDTH-1:0] W_retired
);
    logic             valid;
    logic [WIDTH-1:0] pc, instr, alu, dm, md, mux;
    logic [1:0]       sel;
    logic [4:0]       a3;
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
            alu   <= '0;
            dm    <= '0;
            md    <= '0;
            sel   <= '0;
            a3    <= '0;
        end else if (en) begin
            valid <= M_valid;
            pc    <= M_PC;
            instr <= M_Instr;
            alu   <= M_ALU_O;
            dm    <= M_DM_O;
            md    <= M_MD_O;
            sel   <= M_WDSel;
            a3    <= M_MUXM_RegDst_O;
        end
    end
    // a bubble leaves the count alone; only reset clears it
    always_ff @(posedge clk) begin
        if (reset)
            W_retired <= '0;
        else if (!clr && en && M_valid)
            W_retired <= W_retired + 1'b1;
    end
    always_comb begin
        mux        = sel == 2'd0 ? alu :
                     sel == 2'd1 ? dm  :
                     sel == 2'd2 ? pc + WIDTH'(8) : md;
        W_RegWrite = valid && a3 != 5'd0;
        W_WD       = W_RegWrite ? mux : '0;
        W_A3       = valid ? a3 : 5'd0;
        W_valid    = valid;
        W_PC       = pc;
        W_Instr    = instr;
    end
endmodule
